// File: rtl/mcp_reg_multi.sv
// Multi-channel multicycle-path capture register.
// Each channel latches a source value on SET, then requires the value to stay
// stable for MCP_CYCLES clock edges before committing it to its get output.
// Each channel flags a stability violation in a sticky err bit, cleared by
// clr_err. On a violation the channel either restarts the stability window
// or aborts, depending on ABORT_ON_ERR.
module mcp_reg_multi #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NCH          = 4,
  parameter int unsigned MCP_CYCLES   = 2,
  parameter int unsigned ABORT_ON_ERR = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NCH-1:0]         SET,
  input  logic [NCH*WIDTH-1:0]   val,
  input  logic [NCH-1:0]         clr_err,
  output logic [NCH*WIDTH-1:0]   get,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         err
);

  localparam int unsigned CW = $clog2(MCP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MCP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit SINGLE_EDGE = (MCP_CYCLES == 1);
  localparam bit ABORT       = (ABORT_ON_ERR != 0);

  // Reset value of get: odd bits set, even bits clear (...1010).
  function automatic logic [WIDTH-1:0] reset_pattern();
    logic [WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      p[b] = (b % 2) == 1;
    end
    return p;
  endfunction

  localparam logic [WIDTH-1:0] RST_PAT = reset_pattern();

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    state_e           state_q,  state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] get_q,    get_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic             viol;
    logic [WIDTH-1:0] val_w;
    logic             set_w;
    logic             clr_w;

    assign val_w = val[i*WIDTH +: WIDTH];
    assign set_w = SET[i];
    assign clr_w = clr_err[i];

    // Channel state register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        state_q  <= S_IDLE;
        shadow_q <= '0;
        get_q    <= RST_PAT;
        cnt_q    <= '0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        shadow_q <= shadow_d;
        get_q    <= get_d;
        cnt_q    <= cnt_d;
        busy_q   <= busy_d;
        done_q   <= done_d;
        err_q    <= err_d;
      end
    end

    // Next-state: capture, stability countdown, commit and violation handling.
    always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      get_d    = get_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      viol     = 1'b0;

      case (state_q)
        S_IDLE: begin
          if (set_w) begin
            if (SINGLE_EDGE) begin
              get_d  = val_w;
              done_d = 1'b1;
            end else begin
              shadow_d = val_w;
              cnt_d    = CNT_INIT;
              state_d  = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // SET is deliberately not looked at here: it never restarts a window.
          if (val_w != shadow_q) begin
            viol = 1'b1;
            if (ABORT) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              shadow_d = val_w;
              cnt_d    = CNT_INIT;
            end
          end else if (cnt_q <= CNT_ONE) begin
            get_d   = shadow_q;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      // A violation on the same edge as clr_err keeps err set.
      err_d  = viol | (err_q & ~clr_w);
      busy_d = (state_d == S_WAIT);
    end

    assign get[i*WIDTH +: WIDTH] = get_q;
    assign busy[i]               = busy_q;
    assign done[i]               = done_q;
    assign err[i]                = err_q;
  end

endmodule

// File: tb/tb_mcp_reg_multi.sv
// Bench for mcp_reg_multi: four instances with different parameter sets,
// a time-based reference model, per-cycle comparison and directed checks.
module tb_mcp_reg_multi;

  logic CLK;
  logic RST_N;

  logic [3:0]  set_v [4];
  logic [31:0] val_v [4];
  logic [3:0]  clr_v [4];

  logic [31:0] g0, g1, g2;
  logic [5:0]  g3;
  logic [3:0]  b0, b1, b2, d0, d1, d2, e0, e1, e2;
  logic [1:0]  b3, d3, e3;

  int checks   = 0;
  int failures = 0;

  // Instance configs: {WIDTH, NCH, MCP_CYCLES, ABORT_ON_ERR}
  int cfg_w [4] = '{8, 8, 8, 3};
  int cfg_n [4] = '{4, 4, 4, 2};
  int cfg_m [4] = '{3, 3, 1, 2};
  int cfg_a [4] = '{0, 1, 0, 0};

  mcp_reg_multi #(.WIDTH(8), .NCH(4), .MCP_CYCLES(3), .ABORT_ON_ERR(0)) u_d0 (
    .CLK(CLK), .RST_N(RST_N), .SET(set_v[0]), .val(val_v[0]), .clr_err(clr_v[0]),
    .get(g0), .busy(b0), .done(d0), .err(e0));
  mcp_reg_multi #(.WIDTH(8), .NCH(4), .MCP_CYCLES(3), .ABORT_ON_ERR(1)) u_d1 (
    .CLK(CLK), .RST_N(RST_N), .SET(set_v[1]), .val(val_v[1]), .clr_err(clr_v[1]),
    .get(g1), .busy(b1), .done(d1), .err(e1));
  mcp_reg_multi #(.WIDTH(8), .NCH(4), .MCP_CYCLES(1), .ABORT_ON_ERR(0)) u_d2 (
    .CLK(CLK), .RST_N(RST_N), .SET(set_v[2]), .val(val_v[2]), .clr_err(clr_v[2]),
    .get(g2), .busy(b2), .done(d2), .err(e2));
  mcp_reg_multi #(.WIDTH(3), .NCH(2), .MCP_CYCLES(2), .ABORT_ON_ERR(0)) u_d3 (
    .CLK(CLK), .RST_N(RST_N), .SET(set_v[3][1:0]), .val(val_v[3][5:0]),
    .clr_err(clr_v[3][1:0]),
    .get(g3), .busy(b3), .done(d3), .err(e3));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: a window opens at edge t_start with value shadow; it
  // commits when the value has been seen unchanged through edge
  // t_start + MCP_CYCLES - 1. Any change before then is a violation.
  logic [7:0] m_get    [4][4];
  logic [7:0] m_shadow [4][4];
  bit         m_act    [4][4];
  bit         m_done   [4][4];
  bit         m_err    [4][4];
  int         m_tst    [4][4];
  int         edge_n = 0;
  bit         chk_en = 0;

  logic [7:0] mm, mv;
  bit         ms, mc, mviol;

  always @(posedge CLK) begin
    edge_n = edge_n + 1;
    for (int d = 0; d < 4; d++) begin
      mm = 8'((1 << cfg_w[d]) - 1);
      for (int ch = 0; ch < cfg_n[d]; ch++) begin
        mv = 8'(val_v[d] >> (ch * cfg_w[d])) & mm;
        ms = set_v[d][ch];
        mc = clr_v[d][ch];
        if (!RST_N) begin
          m_get[d][ch]  = 8'hAA & mm;
          m_act[d][ch]  = 0;
          m_done[d][ch] = 0;
          m_err[d][ch]  = 0;
        end else begin
          mviol = 0;
          m_done[d][ch] = 0;
          if (!m_act[d][ch]) begin
            if (ms) begin
              if (cfg_m[d] == 1) begin
                m_get[d][ch]  = mv;
                m_done[d][ch] = 1;
              end else begin
                m_act[d][ch]    = 1;
                m_shadow[d][ch] = mv;
                m_tst[d][ch]    = edge_n;
              end
            end
          end else if (mv != m_shadow[d][ch]) begin
            mviol = 1;
            if (cfg_a[d] != 0) m_act[d][ch] = 0;
            else begin
              m_shadow[d][ch] = mv;
              m_tst[d][ch]    = edge_n;
            end
          end else if (edge_n - m_tst[d][ch] == cfg_m[d] - 1) begin
            m_get[d][ch]  = m_shadow[d][ch];
            m_done[d][ch] = 1;
            m_act[d][ch]  = 0;
          end
          m_err[d][ch] = mviol | (m_err[d][ch] & !mc);
        end
      end
    end
    chk_en = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  logic [31:0] eg;
  logic [3:0]  eb, ed, ee;
  logic [31:0] ag;
  logic [3:0]  ab, ad, ae;

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int d = 0; d < 4; d++) begin
        eg = '0; eb = '0; ed = '0; ee = '0;
        for (int ch = 0; ch < cfg_n[d]; ch++) begin
          eg = eg | (32'(m_get[d][ch]) << (ch * cfg_w[d]));
          eb[ch] = m_act[d][ch];
          ed[ch] = m_done[d][ch];
          ee[ch] = m_err[d][ch];
        end
        case (d)
          0: begin ag = g0; ab = b0; ad = d0; ae = e0; end
          1: begin ag = g1; ab = b1; ad = d1; ae = e1; end
          2: begin ag = g2; ab = b2; ad = d2; ae = e2; end
          default: begin
            ag = {26'b0, g3}; ab = {2'b0, b3}; ad = {2'b0, d3}; ae = {2'b0, e3};
          end
        endcase
        chk($sformatf("dut%0d_get", d),  ag, eg);
        chk($sformatf("dut%0d_busy", d), 32'(ab), 32'(eb));
        chk($sformatf("dut%0d_done", d), 32'(ad), 32'(ed));
        chk($sformatf("dut%0d_err", d),  32'(ae), 32'(ee));
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    RST_N = 1'b0;
    for (int d = 0; d < 4; d++) begin
      set_v[d] = '0; val_v[d] = '0; clr_v[d] = '0;
    end
    tick();
    tick();
    chk("rst_get0", g0, 32'hAAAAAAAA);
    chk("rst_get3", 32'(g3), 32'h12);
    chk("rst_busy0", 32'(b0), 32'h0);
    chk("rst_err0", 32'(e0), 32'h0);
    RST_N = 1'b1;
    tick();

    // Stable capture on dut0 ch0, MCP_CYCLES=3.
    val_v[0][7:0] = 8'h5C; set_v[0][0] = 1'b1;
    tick();
    chk("t1_busy_a", 32'(b0), 32'h1);
    set_v[0][0] = 1'b0;
    tick();
    chk("t1_busy_b", 32'(b0), 32'h1);
    tick();
    chk("t1_get", g0, 32'hAAAAAA5C);
    chk("t1_done", 32'(d0), 32'h1);
    chk("t1_idle", 32'(b0), 32'h0);
    tick();
    chk("t1_done_off", 32'(d0), 32'h0);

    // Violation one edge after SET: restart (dut0) versus abort (dut1).
    val_v[0][15:8] = 8'h11; val_v[1][15:8] = 8'h11;
    set_v[0][1] = 1'b1; set_v[1][1] = 1'b1;
    tick();
    set_v[0][1] = 1'b0; set_v[1][1] = 1'b0;
    val_v[0][15:8] = 8'h22; val_v[1][15:8] = 8'h22;
    tick();
    chk("t2_err_restart", 32'(e0), 32'h2);
    chk("t2_busy_restart", 32'(b0), 32'h2);
    chk("t2_err_abort", 32'(e1), 32'h2);
    chk("t2_busy_abort", 32'(b1), 32'h0);
    tick();
    tick();
    chk("t2_get_restart", g0, 32'hAAAA225C);
    chk("t2_done_restart", 32'(d0), 32'h2);
    chk("t2_get_abort", g1, 32'hAAAAAAAA);
    chk("t2_done_abort", 32'(d1), 32'h0);

    // SET held through WAIT is ignored; SET in the done cycle starts anew.
    val_v[0][23:16] = 8'h33; set_v[0][2] = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_get", g0, 32'hAA33225C);
    chk("t3_done", 32'(d0), 32'h4);
    val_v[0][23:16] = 8'h44;
    tick();
    chk("t3_rebusy", 32'(b0), 32'h4);
    set_v[0][2] = 1'b0;
    tick();
    tick();
    chk("t3_get2", g0, 32'hAA44225C);
    chk("t3_done2", 32'(d0), 32'h4);

    // clr_err alone clears; clr_err with a violation leaves err set.
    clr_v[0][1] = 1'b1;
    tick();
    chk("t4_clr", 32'(e0), 32'h0);
    clr_v[0][1] = 1'b0;
    val_v[0][31:24] = 8'h55; set_v[0][3] = 1'b1;
    tick();
    set_v[0][3] = 1'b0; val_v[0][31:24] = 8'h66; clr_v[0][3] = 1'b1;
    tick();
    chk("t4_set_wins", 32'(e0), 32'h8);
    clr_v[0][3] = 1'b0;
    tick();
    tick();
    chk("t4_get", g0, 32'h6644225C);

    // MCP_CYCLES=1: two channels commit on the SET edge.
    val_v[2] = 32'hFE01_0000; set_v[2] = 4'b1100;
    tick();
    chk("t5_get", g2, 32'hFE01AAAA);
    chk("t5_done", 32'(d2), 32'hC);
    set_v[2] = 4'b0000;
    tick();
    chk("t5_done_off", 32'(d2), 32'h0);

    // WIDTH=3, MCP_CYCLES=2.
    val_v[3][2:0] = 3'b101; set_v[3][0] = 1'b1;
    tick();
    chk("t6_busy", 32'(b3), 32'h1);
    set_v[3][0] = 1'b0;
    tick();
    chk("t6_get", 32'(g3), 32'h15);
    chk("t6_done", 32'(d3), 32'h1);

    // Reset in the middle of a window.
    val_v[0][15:8] = 8'h77; set_v[0][1] = 1'b1;
    tick();
    chk("t7_busy", 32'(b0), 32'h2);
    set_v[0][1] = 1'b0; RST_N = 1'b0;
    tick();
    chk("t7_get", g0, 32'hAAAAAAAA);
    chk("t7_busy_off", 32'(b0), 32'h0);
    chk("t7_err_off", 32'(e0), 32'h0);
    RST_N = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcp_reg_multi.md
Name: mcp_reg_multi

Overview:
- Multi-channel multicycle-path capture register; successor to the single-channel MCP register.
- Each channel accepts a SET request, then checks that its source value stays stable for MCP_CYCLES clock edges before committing it to the output.
- Reports per-channel busy/done status and a sticky stability-violation flag, with configurable retry/abort policy.
- Sits at the destination side of multicycle (slow-settling) datapaths in generated designs. Fully synthesizable; no simulation-only delay modelling.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- NCH, 4, number of independent channels (>=1)
- MCP_CYCLES, 2, edges val must be stable before commit (>=1)
- ABORT_ON_ERR, 0, 0 = restart window on violation; 1 = abort to IDLE, get unchanged

Ports:
- CLK  input  1  clock, all logic on posedge
- RST_N  input  1  reset, synchronous, active-low
- SET  input  NCH  per-channel capture request
- val  input  NCH*WIDTH  source values; channel i = bits [i*WIDTH +: WIDTH]
- clr_err  input  NCH  per-channel clear of err
- get  output  NCH*WIDTH  committed values (registered)
- busy  output  NCH  channel in WAIT state
- done  output  NCH  one-cycle pulse after commit (registered)
- err  output  NCH  sticky stability violation (registered)

Behaviour:
- Reset (RST_N=0 at posedge):
  - every get channel = low WIDTH bits of repeating 2'b10 pattern (WIDTH=8 -> 8'hAA; WIDTH=3 -> 3'b010)
  - busy=0, done=0, err=0, counters=0, all channels IDLE
  - reset overrides all other inputs, including mid-window channels
- Per-channel FSM: IDLE, WAIT. Channels are fully independent; channel i uses only SET[i], val slice i and clr_err[i].
- IDLE, SET=1, MCP_CYCLES=1: get<=val at the same edge; done=1 next cycle; stay IDLE.
- IDLE, SET=1, MCP_CYCLES>1: shadow<=val, cnt<=MCP_CYCLES-1, go WAIT, busy=1.
- WAIT, each edge:
  - val==shadow and cnt>1: cnt<=cnt-1.
  - val==shadow and cnt==1: get<=shadow, done=1 for one cycle, go IDLE, busy=0. get is therefore updated at edge t0+MCP_CYCLES-1, where t0 is the SET edge.
  - val!=shadow: err<=1.
    - ABORT_ON_ERR=0: shadow<=val, cnt<=MCP_CYCLES-1, stay WAIT.
    - ABORT_ON_ERR=1: go IDLE, get unchanged, no done.
  - A mismatch on the final edge is a violation (no commit).
- SET while in WAIT: ignored; it neither restarts the window nor sets err.
- SET in the cycle done is high: channel is already IDLE, so a new capture is accepted.
- err is sticky until clr_err=1. If a violation and clr_err occur on the same edge, err=1 (set wins).
- Counter width = $clog2(MCP_CYCLES+1).
- done is never asserted together with an err-setting event on the same channel edge.

Test Plan:
- Reset, WIDTH=8, NCH=4 -> get=32'hAAAAAAAA, busy=0, done=0, err=0; WIDTH=3 -> each channel 3'b010.
- MCP_CYCLES=3, ch0: SET with val=8'h5C held stable -> busy=1 for 2 cycles; get[7:0]=8'h5C after edge t0+2; done pulses exactly one cycle; other channels unchanged.
- MCP_CYCLES=3, ABORT_ON_ERR=0: val changes 8'h11->8'h22 one edge after SET, then held -> err=1, window restarts, commit 8'h22 two edges after the change.
- Same stimulus with ABORT_ON_ERR=1 -> err=1, busy drops, get keeps its previous value, no done.
- SET repeated during WAIT -> ignored, commit timing unchanged. clr_err with simultaneous violation -> err remains 1; clr_err alone -> err=0 next cycle.
- MCP_CYCLES=1, SET on ch2 and ch3 same edge with 8'h01/8'hFE -> both committed at that edge, done[3:2]=2'b11 next cycle. Reset asserted mid-WAIT on ch1 -> ch1 returns to 8'hAA, busy=0.
